// File: rtl/bcd2bin_seq_arbiter.sv
// bcd2bin_seq_arbiter: round-robin shared iterative BCD-to-binary converter, one digit per clock, MSD first
module bcd2bin_seq_arbiter #(
    parameter int NDIG = 4,
    parameter int OUTW = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [4*NDIG-1:0] req0_bcd,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [4*NDIG-1:0] req1_bcd,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [OUTW-1:0]   res_bin,
    output logic              res_id,
    output logic              res_err,
    output logic              busy
);
    localparam int IW = NDIG > 1 ? $clog2(NDIG) : 1;
    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
    state_t            r_state, w_next;
    logic [4*NDIG-1:0] r_bcd;
    logic [OUTW-1:0]   r_acc, w_sum;
    logic [IW-1:0]     r_cnt;
    logic              r_err, r_id, r_rr_last;
    logic              w_g0, w_g1, w_accept;
    logic [3:0]        w_dig;
    assign w_g0       = req0_valid && (!req1_valid || r_rr_last);
    assign w_g1       = req1_valid && (!req0_valid || !r_rr_last);
    assign w_accept   = (r_state == IDLE) && !rst && (w_g0 || w_g1);
    assign req0_ready = w_accept && w_g0;
    assign req1_ready = w_accept && w_g1;
    assign busy       = r_state != IDLE;
    // the captured word shifts left each step, so the digit in use is always the top nibble
    assign w_dig      = r_bcd[4*NDIG-1 -: 4];
    assign w_sum      = (r_acc << 3) + (r_acc << 1) + OUTW'(w_dig);
    always_ff @(posedge clk)
        r_state <= rst ? IDLE : w_next;
    always_comb begin
        w_next = r_state;
        if (r_state == IDLE && w_accept)
            w_next = CONV;
        else if (r_state == CONV && r_cnt == '0)
            w_next = DONE;
        else if (r_state == DONE && res_ready)
            w_next = IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_last <= 1'b1;
            r_bcd     <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
            r_id      <= 1'b0;
            res_valid <= 1'b0;
            res_bin   <= '0;
            res_id    <= 1'b0;
            res_err   <= 1'b0;
        end else if (r_state == IDLE) begin
            if (w_accept) begin
                r_bcd     <= w_g1 ? req1_bcd : req0_bcd;
                r_id      <= w_g1;
                r_rr_last <= w_g1;
                r_acc     <= '0;
                r_err     <= 1'b0;
                r_cnt     <= IW'(NDIG - 1);
            end
        end else if (r_state == CONV) begin
            r_acc <= w_sum;
            r_err <= r_err | (w_dig > 4'd9);
            r_bcd <= r_bcd << 4;
            r_cnt <= r_cnt - IW'(1);
            if (r_cnt == '0) begin
                res_bin   <= w_sum;
                res_id    <= r_id;
                res_err   <= r_err | (w_dig > 4'd9);
                res_valid <= 1'b1;
            end
        end else if (res_ready) begin
            res_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_bcd2bin_seq_arbiter.sv
// tb_bcd2bin_seq_arbiter: directed and soak checks of the shared BCD-to-binary converter
module tb_bcd2bin_seq_arbiter;
    localparam int N = 50;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        v0 = 1'b0, v1 = 1'b0, r0, r1;
    logic [15:0] b0 = '0, b1 = '0;
    logic        res_valid, res_ready = 1'b0, res_id, res_err, busy;
    logic [13:0] res_bin;
    int          checks = 0, errors = 0;
    int          q0[$], q1[$];
    int          sent0, sent1, got, lastg;
    bit          a0, a1;
    always #5 clk = ~clk;
    bcd2bin_seq_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(v0), .req0_ready(r0), .req0_bcd(b0),
        .req1_valid(v1), .req1_ready(r1), .req1_bcd(b1),
        .res_valid(res_valid), .res_ready(res_ready), .res_bin(res_bin),
        .res_id(res_id), .res_err(res_err), .busy(busy)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask
    task automatic do_reset();
        rst = 1'b1; v0 = 1'b0; v1 = 1'b0; res_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask
    task automatic get_res(input string tag, input int eb, input logic ei, input logic ee);
        bit found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            @(negedge clk);
            #1;
            found = res_valid;
        end
        chk({tag, "_seen"}, 32'(found), 1);
        if (found) begin
            chk({tag, "_bin"}, 32'(res_bin), eb);
            chk({tag, "_id"}, 32'(res_id), 32'(ei));
            chk({tag, "_err"}, 32'(res_err), 32'(ee));
        end
    endtask
    function automatic logic [15:0] rbcd();
        logic [15:0] r;
        for (int k = 0; k < 4; k++) r[4*k +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction
    function automatic int bcdval(input logic [15:0] w);
        return int'(w[15:12]) * 1000 + int'(w[11:8]) * 100 + int'(w[7:4]) * 10 + int'(w[3:0]);
    endfunction
    initial begin
        // reset state and single conversion with exact latency
        do_reset();
        #1;
        chk("rst_valid", 32'(res_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_bin", 32'(res_bin), 0);
        chk("rst_ready0", 32'(r0), 0);
        @(negedge clk);
        v0 = 1'b1; b0 = 16'h1234; res_ready = 1'b1;
        #1;
        chk("t1_ready0", 32'(r0), 1);
        chk("t1_ready1", 32'(r1), 0);
        @(negedge clk);
        v0 = 1'b0;
        #1;
        chk("t1_ready_once", 32'(r0), 0);
        chk("t1_busy", 32'(busy), 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("t1_early", 32'(res_valid), 0);
        end
        @(negedge clk);
        #1;
        chk("t1_valid", 32'(res_valid), 1);
        chk("t1_bin", 32'(res_bin), 1234);
        chk("t1_id", 32'(res_id), 0);
        chk("t1_err", 32'(res_err), 0);
        @(negedge clk);
        #1;
        chk("t1_valid_drop", 32'(res_valid), 0);
        chk("t1_idle", 32'(busy), 0);
        // fairness
        do_reset();
        v0 = 1'b1; b0 = 16'h9999; v1 = 1'b1; b1 = 16'h0042; res_ready = 1'b1;
        #1;
        chk("t2_g0", 32'(r0), 1);
        chk("t2_g0_not1", 32'(r1), 0);
        @(negedge clk);
        v0 = 1'b0;
        get_res("t2_a", 9999, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        chk("t2_g1", 32'(r1), 1);
        @(negedge clk);
        v1 = 1'b0;
        get_res("t2_b", 42, 1'b1, 1'b0);
        @(negedge clk);
        v0 = 1'b1; b0 = 16'h0001; v1 = 1'b1; b1 = 16'h0002;
        #1;
        chk("t2_g0_again", 32'(r0), 1);
        chk("t2_g0_again_not1", 32'(r1), 0);
        @(negedge clk);
        v0 = 1'b0;
        #1;
        chk("t2_conv_no_ready", 32'(r1), 0);
        get_res("t2_c", 1, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        chk("t2_g1_again", 32'(r1), 1);
        @(negedge clk);
        v1 = 1'b0;
        get_res("t2_d", 2, 1'b1, 1'b0);
        // backpressure with req1 pending
        @(negedge clk);
        res_ready = 1'b0; v0 = 1'b1; b0 = 16'h0777;
        @(negedge clk);
        v0 = 1'b0; v1 = 1'b1; b1 = 16'h0321;
        get_res("t3_a", 777, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk("t3_hold_valid", 32'(res_valid), 1);
            chk("t3_hold_bin", 32'(res_bin), 777);
            chk("t3_hold_id", 32'(res_id), 0);
            chk("t3_hold_err", 32'(res_err), 0);
            chk("t3_hold_ready1", 32'(r1), 0);
        end
        res_ready = 1'b1;
        #1;
        chk("t3_hs_ready1", 32'(r1), 0);
        @(negedge clk);
        #1;
        chk("t3_after_valid", 32'(res_valid), 0);
        chk("t3_after_ready1", 32'(r1), 1);
        @(negedge clk);
        v1 = 1'b0;
        get_res("t3_b", 321, 1'b1, 1'b0);
        // invalid digit
        @(negedge clk);
        v1 = 1'b1; b1 = 16'h12A4;
        #1;
        chk("t4_ready1", 32'(r1), 1);
        @(negedge clk);
        v1 = 1'b0;
        get_res("t4", 1304, 1'b1, 1'b1);
        // reset during conversion
        @(negedge clk);
        v0 = 1'b1; b0 = 16'h1111;
        @(negedge clk);
        v0 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t5_valid", 32'(res_valid), 0);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_bin", 32'(res_bin), 0);
        chk("t5_id", 32'(res_id), 0);
        chk("t5_err", 32'(res_err), 0);
        chk("t5_ready0", 32'(r0), 0);
        chk("t5_ready1", 32'(r1), 0);
        @(negedge clk);
        v0 = 1'b1; b0 = 16'h0500; v1 = 1'b1; b1 = 16'h0600;
        #1;
        chk("t5_g0", 32'(r0), 1);
        chk("t5_g0_not1", 32'(r1), 0);
        @(negedge clk);
        v0 = 1'b0;
        get_res("t5_a", 500, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        chk("t5_g1", 32'(r1), 1);
        @(negedge clk);
        v1 = 1'b0;
        get_res("t5_b", 600, 1'b1, 1'b0);
        // random soak
        do_reset();
        lastg = 1; a0 = 1'b0; a1 = 1'b0; sent0 = 0; sent1 = 0; got = 0;
        for (int cyc = 0; cyc < 6000 && got < 2 * N; cyc++) begin
            @(negedge clk);
            if (a0) begin q0.push_back(bcdval(b0)); v0 = 1'b0; end
            if (a1) begin q1.push_back(bcdval(b1)); v1 = 1'b0; end
            if (!v0 && sent0 < N && $urandom_range(0, 2) == 0) begin b0 = rbcd(); v0 = 1'b1; sent0++; end
            if (!v1 && sent1 < N && $urandom_range(0, 2) == 0) begin b1 = rbcd(); v1 = 1'b1; sent1++; end
            res_ready = 1'($urandom_range(0, 1));
            #1;
            a0 = r0; a1 = r1;
            if (a0 && v1) chk("soak_fair0", 32'(lastg), 1);
            if (a1 && v0) chk("soak_fair1", 32'(lastg), 0);
            if (a0) lastg = 0;
            if (a1) lastg = 1;
            if (res_valid && res_ready) begin
                got++;
                chk("soak_err", 32'(res_err), 0);
                if (res_id == 1'b0) begin
                    if (q0.size() == 0) chk("soak_dup0", 0, 1);
                    else chk("soak_bin0", 32'(res_bin), 32'(q0.pop_front()));
                end else begin
                    if (q1.size() == 0) chk("soak_dup1", 0, 1);
                    else chk("soak_bin1", 32'(res_bin), 32'(q1.pop_front()));
                end
            end
        end
        chk("soak_count", 32'(got), 2 * N);
        chk("soak_left0", 32'(q0.size()), 0);
        chk("soak_left1", 32'(q1.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
